// File: rtl/dcpu16_marb_if.sv
// Bus bundle between the DCPU16 memory bus unit (F-BUS, G-BUS) and the shared memory port.
// The arbiter uses the slave modport; the CPU/memory side uses the master modport.
interface dcpu16_marb_if;
   logic [15:0] f_adr;
   logic        f_stb;
   logic        f_wre;
   logic [15:0] f_dto;
   logic [15:0] f_dti;
   logic        f_ack;

   logic [15:0] g_adr;
   logic        g_stb;
   logic        g_wre;
   logic [15:0] g_dto;
   logic [15:0] g_dti;
   logic        g_ack;

   logic [15:0] m_adr;
   logic        m_stb;
   logic        m_wre;
   logic [15:0] m_dto;
   logic [15:0] m_dti;
   logic        m_ack;

   modport slave (
      input  f_adr, f_stb, f_wre, f_dto,
      output f_dti, f_ack,
      input  g_adr, g_stb, g_wre, g_dto,
      output g_dti, g_ack,
      output m_adr, m_stb, m_wre, m_dto,
      input  m_dti, m_ack
   );

   modport master (
      output f_adr, f_stb, f_wre, f_dto,
      input  f_dti, f_ack,
      output g_adr, g_stb, g_wre, g_dto,
      input  g_dti, g_ack,
      input  m_adr, m_stb, m_wre, m_dto,
      output m_dti, m_ack
   );
endinterface

// File: rtl/dcpu16_marb.sv
// Two-master (F-BUS / G-BUS) arbiter onto a single-port memory; all outputs registered.
// Define DCPU16_MARB_RR_EN for round-robin tie-breaking; otherwise F-BUS wins ties.
module dcpu16_marb (
   input  logic          clk,
   input  logic          rst,
   dcpu16_marb_if.slave  bus
);
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BUSY_F,
      ST_BUSY_G,
      ST_RESP_F,
      ST_RESP_G
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic        r_last_g;
   logic [15:0] r_m_adr;
   logic        r_m_stb;
   logic        r_m_wre;
   logic [15:0] r_m_dto;
   logic [15:0] r_f_dti;
   logic [15:0] r_g_dti;
   logic        r_f_ack;
   logic        r_g_ack;

   logic        w_arb;
   logic        w_f_elig;
   logic        w_g_elig;
   logic        w_grant_f;
   logic        w_grant_g;
   logic        w_done;

   always_comb begin
      w_state_next = r_state;
      w_grant_f    = 1'b0;
      w_grant_g    = 1'b0;
      w_done       = 1'b0;
      w_arb        = (r_state == ST_IDLE) || (r_state == ST_RESP_F) || (r_state == ST_RESP_G);
      // The master being acked still shows its finished request on stb, so mask it.
      w_f_elig     = bus.f_stb && (r_state != ST_RESP_F);
      w_g_elig     = bus.g_stb && (r_state != ST_RESP_G);

      if (w_arb) begin
         if (w_f_elig && w_g_elig) begin
`ifdef DCPU16_MARB_RR_EN
            w_grant_f = r_last_g;
            w_grant_g = !r_last_g;
`else
            w_grant_f = 1'b1;
`endif
         end else begin
            w_grant_f = w_f_elig;
            w_grant_g = w_g_elig;
         end

         if (w_grant_f) begin
            w_state_next = ST_BUSY_F;
         end else if (w_grant_g) begin
            w_state_next = ST_BUSY_G;
         end else begin
            w_state_next = ST_IDLE;
         end
      end else begin
         case (r_state)
            ST_BUSY_F: begin
               if (bus.m_ack) begin
                  w_state_next = ST_RESP_F;
                  w_done       = 1'b1;
               end
            end
            ST_BUSY_G: begin
               if (bus.m_ack) begin
                  w_state_next = ST_RESP_G;
                  w_done       = 1'b1;
               end
            end
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_last_g <= 1'b1;
         r_m_adr  <= 16'h0000;
         r_m_stb  <= 1'b0;
         r_m_wre  <= 1'b0;
         r_m_dto  <= 16'h0000;
         r_f_dti  <= 16'h0000;
         r_g_dti  <= 16'h0000;
         r_f_ack  <= 1'b0;
         r_g_ack  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_f_ack <= (w_state_next == ST_RESP_F);
         r_g_ack <= (w_state_next == ST_RESP_G);

         if (w_grant_f) begin
            r_m_adr  <= bus.f_adr;
            r_m_wre  <= bus.f_wre;
            r_m_dto  <= bus.f_dto;
            r_m_stb  <= 1'b1;
            r_last_g <= 1'b0;
         end else if (w_grant_g) begin
            r_m_adr  <= bus.g_adr;
            r_m_wre  <= bus.g_wre;
            r_m_dto  <= bus.g_dto;
            r_m_stb  <= 1'b1;
            r_last_g <= 1'b1;
         end

         // Write cycles also load dti; the master ignores it.
         if (w_done) begin
            r_m_stb <= 1'b0;
            if (r_state == ST_BUSY_F) begin
               r_f_dti <= bus.m_dti;
            end else begin
               r_g_dti <= bus.m_dti;
            end
         end
      end
   end

   assign bus.m_adr = r_m_adr;
   assign bus.m_stb = r_m_stb;
   assign bus.m_wre = r_m_wre;
   assign bus.m_dto = r_m_dto;
   assign bus.f_dti = r_f_dti;
   assign bus.g_dti = r_g_dti;
   assign bus.f_ack = r_f_ack;
   assign bus.g_ack = r_g_ack;
endmodule

// File: tb/tb_dcpu16_marb.sv
// Directed self-checking bench for dcpu16_marb with a wait-state-programmable memory responder.
module tb_dcpu16_marb;
   logic clk;
   logic rst;
   dcpu16_marb_if bus ();

   dcpu16_marb dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

`ifdef DCPU16_MARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   int          checks = 0;
   int          errors = 0;
   int          waits = 0;
   int          wcnt = 0;
   logic        force_ack = 1'b0;
   logic [15:0] mem_data = 16'h0000;
   logic [15:0] exp_f_dti = 16'h0000;
   logic [15:0] exp_g_dti = 16'h0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: acks once wcnt reaches the programmed number of wait states.
   always @(posedge clk) begin
      if (!bus.m_stb) wcnt <= 0;
      else if (!bus.m_ack) wcnt <= wcnt + 1;
   end
   always_comb bus.m_ack = force_ack | (bus.m_stb && (wcnt >= waits));
   assign bus.m_dti = mem_data;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " m_adr"}, bus.m_adr, 16'h0000);
      chk({tag, " m_stb"}, {15'd0, bus.m_stb}, 16'd0);
      chk({tag, " m_wre"}, {15'd0, bus.m_wre}, 16'd0);
      chk({tag, " m_dto"}, bus.m_dto, 16'h0000);
      chk({tag, " f_ack"}, {15'd0, bus.f_ack}, 16'd0);
      chk({tag, " g_ack"}, {15'd0, bus.g_ack}, 16'd0);
      chk({tag, " f_dti"}, bus.f_dti, 16'h0000);
      chk({tag, " g_dti"}, bus.g_dti, 16'h0000);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic is_f;
      rst = 1'b1;
      bus.f_adr = 16'h0; bus.f_stb = 1'b0; bus.f_wre = 1'b0; bus.f_dto = 16'h0;
      bus.g_adr = 16'h0; bus.g_stb = 1'b0; bus.g_wre = 1'b0; bus.g_dto = 16'h0;
      step();
      step();
      chk_reset_vals("reset");
      rst = 1'b0;
      step();

      // Single G read, zero wait
      waits = 0;
      mem_data = 16'h1234;
      bus.g_adr = 16'h0010;
      bus.g_stb = 1'b1;
      step();
      chk("g1 m_stb", {15'd0, bus.m_stb}, 16'd1);
      chk("g1 m_adr", bus.m_adr, 16'h0010);
      chk("g1 m_wre", {15'd0, bus.m_wre}, 16'd0);
      chk("g1 g_ack early", {15'd0, bus.g_ack}, 16'd0);
      step();
      chk("g1 g_ack", {15'd0, bus.g_ack}, 16'd1);
      chk("g1 g_dti", bus.g_dti, 16'h1234);
      chk("g1 f_ack", {15'd0, bus.f_ack}, 16'd0);
      chk("g1 m_stb off", {15'd0, bus.m_stb}, 16'd0);
      exp_g_dti = 16'h1234;
      bus.g_stb = 1'b0;
      step();
      chk("g1 g_ack pulse", {15'd0, bus.g_ack}, 16'd0);
      chk("g1 idle m_stb", {15'd0, bus.m_stb}, 16'd0);
      $display("txn: G read 0010 -> %h", bus.g_dti);

      // Both held, zero wait, four transfers: F,G,F,G
      bus.f_adr = 16'h0001;
      bus.g_adr = 16'h0002;
      bus.f_stb = 1'b1;
      bus.g_stb = 1'b1;
      for (int k = 0; k < 4; k++) begin
         is_f = (k % 2 == 0);
         step();
         chk("tie m_stb", {15'd0, bus.m_stb}, 16'd1);
         chk("tie m_adr", bus.m_adr, is_f ? 16'h0001 : 16'h0002);
         mem_data = 16'h0100 + 16'(k);
         step();
         chk("tie f_ack", {15'd0, bus.f_ack}, {15'd0, is_f});
         chk("tie g_ack", {15'd0, bus.g_ack}, {15'd0, !is_f});
         if (is_f) begin
            chk("tie f_dti", bus.f_dti, 16'h0100 + 16'(k));
            exp_f_dti = 16'h0100 + 16'(k);
         end else begin
            chk("tie g_dti", bus.g_dti, 16'h0100 + 16'(k));
            exp_g_dti = 16'h0100 + 16'(k);
         end
         $display("txn: tie transfer %0d granted %s", k, is_f ? "F" : "G");
         if (k == 3) begin
            bus.f_stb = 1'b0;
            bus.g_stb = 1'b0;
         end
      end
      step();
      chk("tie end f_ack", {15'd0, bus.f_ack}, 16'd0);
      chk("tie end g_ack", {15'd0, bus.g_ack}, 16'd0);
      chk("tie end m_stb", {15'd0, bus.m_stb}, 16'd0);

      // Single F write, 3 wait states
      waits = 3;
      mem_data = 16'h7777;
      bus.f_adr = 16'h8000;
      bus.f_dto = 16'hBEEF;
      bus.f_wre = 1'b1;
      bus.f_stb = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         chk("fw m_stb", {15'd0, bus.m_stb}, 16'd1);
         chk("fw m_wre", {15'd0, bus.m_wre}, 16'd1);
         chk("fw m_dto", bus.m_dto, 16'hBEEF);
         chk("fw m_adr", bus.m_adr, 16'h8000);
         chk("fw f_ack early", {15'd0, bus.f_ack}, 16'd0);
      end
      step();
      chk("fw f_ack", {15'd0, bus.f_ack}, 16'd1);
      chk("fw g_ack", {15'd0, bus.g_ack}, 16'd0);
      chk("fw f_dti", bus.f_dti, 16'h7777);
      exp_f_dti = 16'h7777;
      bus.f_stb = 1'b0;
      bus.f_wre = 1'b0;
      step();
      chk("fw f_ack pulse", {15'd0, bus.f_ack}, 16'd0);
      $display("txn: F write 8000 <- BEEF");

      // Idle tie with F last served: round-robin picks G, fixed priority picks F
      waits = 0;
      bus.f_adr = 16'h0011;
      bus.g_adr = 16'h0022;
      bus.f_stb = 1'b1;
      bus.g_stb = 1'b1;
      step();
      chk("tie2 m_adr", bus.m_adr, RR ? 16'h0022 : 16'h0011);
      mem_data = 16'h4444;
      step();
      chk("tie2 f_ack", {15'd0, bus.f_ack}, {15'd0, !RR});
      chk("tie2 g_ack", {15'd0, bus.g_ack}, {15'd0, RR});
      if (RR) exp_g_dti = 16'h4444;
      else exp_f_dti = 16'h4444;
      bus.f_stb = 1'b0;
      bus.g_stb = 1'b0;
      step();
      $display("txn: idle tie after F granted %s", RR ? "G" : "F");

      // Spurious m_ack while idle
      force_ack = 1'b1;
      mem_data = 16'hDEAD;
      for (int c = 0; c < 2; c++) begin
         step();
         chk("spur f_ack", {15'd0, bus.f_ack}, 16'd0);
         chk("spur g_ack", {15'd0, bus.g_ack}, 16'd0);
         chk("spur m_stb", {15'd0, bus.m_stb}, 16'd0);
         chk("spur f_dti", bus.f_dti, exp_f_dti);
         chk("spur g_dti", bus.g_dti, exp_g_dti);
      end
      force_ack = 1'b0;
      $display("txn: spurious m_ack ignored");

      // Reset during BUSY_G with memory still waiting
      waits = 100;
      bus.g_adr = 16'h0042;
      bus.g_stb = 1'b1;
      step();
      chk("rstg m_stb", {15'd0, bus.m_stb}, 16'd1);
      chk("rstg m_adr", bus.m_adr, 16'h0042);
      step();
      chk("rstg g_ack", {15'd0, bus.g_ack}, 16'd0);
      rst = 1'b1;
      step();
      chk_reset_vals("rstg");
      rst = 1'b0;
      bus.g_stb = 1'b0;
      waits = 0;
      force_ack = 1'b1;
      step();
      step();
      chk("rstg late f_ack", {15'd0, bus.f_ack}, 16'd0);
      chk("rstg late g_ack", {15'd0, bus.g_ack}, 16'd0);
      chk("rstg late g_dti", bus.g_dti, 16'h0000);
      force_ack = 1'b0;
      mem_data = 16'h5555;
      bus.f_adr = 16'h0005;
      bus.f_stb = 1'b1;
      step();
      chk("rstf m_adr", bus.m_adr, 16'h0005);
      chk("rstf m_stb", {15'd0, bus.m_stb}, 16'd1);
      step();
      chk("rstf f_ack", {15'd0, bus.f_ack}, 16'd1);
      chk("rstf f_dti", bus.f_dti, 16'h5555);
      bus.f_stb = 1'b0;
      step();
      chk("rstf f_ack pulse", {15'd0, bus.f_ack}, 16'd0);
      $display("txn: F read 0005 after reset -> %h", bus.f_dti);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
